// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency word-addressed data memory behind valid/ready request/response channels
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 16384,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IdxW = $clog2(MEM_DEPTH);
  localparam int CntW = $clog2(LATENCY) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  // A zero latency would collapse WAIT into IDLE; a non-power-of-two depth breaks address wrapping.
  if (LATENCY < 1) begin : gBadLatency
    $error("data_mem_responder: LATENCY must be >= 1");
  end
  if ((MEM_DEPTH < 2) || ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0)) begin : gBadDepth
    $error("data_mem_responder: MEM_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [CntW-1:0]       cnt;
  logic [CntW-1:0]       cntNext;
  logic                  acceptReq;
  logic                  doAccess;
  logic                  respDone;

  logic                  latWrite;
  logic                  latMisalign;
  logic [IdxW-1:0]       latIdx;
  logic [DATA_WIDTH-1:0] latWdata;

  logic                  respValidQ;
  logic [DATA_WIDTH-1:0] respRdataQ;
  logic                  respErrQ;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address bits above the word index only wrap the address space; they carry no state.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[ADDR_WIDTH-1:IdxW+2];

  assign req_ready  = (state == IDLE) && reset;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign resp_err   = respErrQ;

  // State register and latency down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state decode: accept in IDLE, count down in WAIT, hold in RESP until the handshake.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    acceptReq = 1'b0;
    doAccess  = 1'b0;
    respDone  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          acceptReq = 1'b1;
          cntNext   = CntLoad;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          doAccess  = 1'b1;
          stateNext = RESP;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      RESP: begin
        if (respValidQ && resp_ready) begin
          respDone  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture the request on acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latWrite    <= 1'b0;
      latMisalign <= 1'b0;
      latIdx      <= '0;
      latWdata    <= '0;
    end else if (acceptReq) begin
      latWrite    <= req_write;
      latMisalign <= |req_addr[1:0];
      latIdx      <= req_addr[IdxW+1:2];
      latWdata    <= req_wdata;
    end
  end

  // Response registers: loaded on the WAIT->RESP edge, valid dropped on the handshake, data held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      respValidQ <= 1'b0;
      respRdataQ <= '0;
      respErrQ   <= 1'b0;
    end else if (doAccess) begin
      respValidQ <= 1'b1;
      if (latMisalign) begin
        respRdataQ <= '0;
        respErrQ   <= 1'b1;
      end else if (latWrite) begin
        respRdataQ <= '0;
        respErrQ   <= 1'b0;
      end else begin
        respRdataQ <= mem[latIdx];
        respErrQ   <= 1'b0;
      end
    end else if (respDone) begin
      respValidQ <= 1'b0;
    end
  end

  // Storage array: cleared by reset, written only by an aligned store at the end of WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (doAccess && latWrite && !latMisalign) begin
      mem[latIdx] <= latWdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - table-driven bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        respReady = 1'b0;

  logic        rdy1, vld1, err1, rdy2, vld2, err2;
  logic [31:0] rd1, rd2;
  logic        reqReadyS, respValidS, respErrS;
  logic [31:0] respRdataS;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid & ~sel), .req_ready(rdy1), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(vld1), .resp_ready(respReady & ~sel), .resp_rdata(rd1), .resp_err(err1)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(16), .LATENCY(1)) dutLat1 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid & sel), .req_ready(rdy2), .req_write(reqWrite),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(vld2), .resp_ready(respReady & sel), .resp_rdata(rd2), .resp_err(err2)
  );

  assign reqReadyS  = sel ? rdy2 : rdy1;
  assign respValidS = sel ? vld2 : vld1;
  assign respRdataS = sel ? rd2 : rd1;
  assign respErrS   = sel ? err2 : err1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] expRdata;
    logic        expErr;
  } vecT;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic runTxn(input string nm, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall,
                        input logic [31:0] expR, input logic expE, input int expLat);
    int waitCnt;
    int lat;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wdata; respReady = 1'b0;
    waitCnt = 0;
    while (!reqReadyS && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    chk({nm, "_ready"}, {31'b0, reqReadyS}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    lat = 0;
    while (!respValidS && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, expLat);
    chk({nm, "_rdata"}, respRdataS, expR);
    chk({nm, "_err"}, {31'b0, respErrS}, {31'b0, expE});
    for (int i = 0; i < stall; i++) begin
      reqValid = i[0]; reqWrite = 1'b1; reqAddr = 32'h10; reqWdata = 32'h0BAD0BAD;
      @(negedge clk);
      chk({nm, "_stall_valid"}, {31'b0, respValidS}, 32'd1);
      chk({nm, "_stall_rdata"}, respRdataS, expR);
      chk({nm, "_stall_err"}, {31'b0, respErrS}, {31'b0, expE});
      chk({nm, "_stall_ready"}, {31'b0, reqReadyS}, 32'd0);
    end
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
    chk({nm, "_hs_valid"}, {31'b0, respValidS}, 32'd0);
    chk({nm, "_hs_rdata_hold"}, respRdataS, expR);
    chk({nm, "_hs_idle"}, {31'b0, reqReadyS}, 32'd1);
  endtask

  initial begin
    vecT vecs[8];
    logic seenValid;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 5, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0012, 32'h0000_0055, 0, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0040, 32'h0000_1234, 0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0, 32'h0000_1234, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 0, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 0, 32'h0000_0000, 1'b0};

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, rdy1}, 32'd0);
    chk("rst_resp_valid", {31'b0, vld1}, 32'd0);
    chk("rst_resp_rdata", rd1, 32'd0);
    chk("rst_resp_err", {31'b0, err1}, 32'd0);
    reset = 1'b1;
    #1;
    chk("release_req_ready", {31'b0, rdy1}, 32'd1);

    for (int v = 0; v < 8; v++) begin
      runTxn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata,
             vecs[v].stall, vecs[v].expRdata, vecs[v].expErr, 3);
    end

    // Reset while a store sits in WAIT: nothing committed, no response.
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20; reqWdata = 32'hCAFE_F00D;
    chk("midrst_ready", {31'b0, rdy1}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_async_ready", {31'b0, rdy1}, 32'd0);
    chk("midrst_async_valid", {31'b0, vld1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seenValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld1) seenValid = 1'b1;
    end
    chk("midrst_no_resp", {31'b0, seenValid}, 32'd0);
    runTxn("midrst_load", 1'b0, 32'h20, 32'h0, 0, 32'h0000_0000, 1'b0, 3);
    runTxn("midrst_old_cleared", 1'b0, 32'h10, 32'h0, 0, 32'h0000_0000, 1'b0, 3);

    // Single-cycle latency instance with wrap-around.
    sel = 1'b1;
    runTxn("lat1_store", 1'b1, 32'h40, 32'h0000_1234, 0, 32'h0000_0000, 1'b0, 1);
    runTxn("lat1_load", 1'b0, 32'h00, 32'h0, 2, 32'h0000_1234, 1'b0, 1);
    runTxn("lat1_misalign", 1'b0, 32'h41, 32'h0, 0, 32'h0000_0000, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
